writeback_ctrl: RTL and testbench

- Write-side owner of the integer register file.
- Merges single-cycle ALU results and multi-cycle load (LSU) results into the register file's single write port (we/rd/rd_data).
- Holds a one-entry LSU skid buffer and enforces a starvation bound.
- Keeps a pending-load scoreboard that tells decode when a source or destination register is not yet written.

---
 rtl/writeback_ctrl_pkg.sv | 20 ++
 rtl/writeback_ctrl_if.sv | 48 ++++
 rtl/writeback_ctrl_scoreboard.sv | 36 +++
 rtl/writeback_ctrl.sv | 115 +++++++++++
 tb/tb_writeback_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_ctrl_pkg.sv
// Shared types and constants for the register-file writeback path.
// Covers result routing, the load skid buffer and the pending-load scoreboard.
package writeback_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;

endpackage

// File: rtl/writeback_ctrl_if.sv
// Bundle of ALU/LSU result handshakes, load-issue tracking, decode hazard query
// and register-file write port seen by the writeback controller.
interface writeback_ctrl_if #(
    parameter int XLEN = writeback_ctrl_pkg::XLEN_DEFAULT
);
    import writeback_ctrl_pkg::*;

    logic                  alu_valid_i;
    logic                  alu_ready_o;
    logic [REG_ADDR_W-1:0] alu_rd_i;
    logic [XLEN-1:0]       alu_data_i;

    logic                  lsu_valid_i;
    logic                  lsu_ready_o;
    logic [REG_ADDR_W-1:0] lsu_rd_i;
    logic [XLEN-1:0]       lsu_data_i;

    logic                  issue_valid_i;
    logic [REG_ADDR_W-1:0] issue_rd_i;

    logic [REG_ADDR_W-1:0] rs1_i;
    logic [REG_ADDR_W-1:0] rs2_i;
    logic [REG_ADDR_W-1:0] rdq_i;
    logic                  hazard_o;

    logic                  rf_we_o;
    logic [REG_ADDR_W-1:0] rf_rd_o;
    logic [XLEN-1:0]       rf_rd_data_o;

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        output issue_valid_i, issue_rd_i,
        output rs1_i, rs2_i, rdq_i,
        input  alu_ready_o, lsu_ready_o, hazard_o,
        input  rf_we_o, rf_rd_o, rf_rd_data_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  issue_valid_i, issue_rd_i,
        input  rs1_i, rs2_i, rdq_i,
        output alu_ready_o, lsu_ready_o, hazard_o,
        output rf_we_o, rf_rd_o, rf_rd_data_o
    );

endinterface

// File: rtl/writeback_ctrl_scoreboard.sv
// Pending-load mask: one bit per architectural register, x0 never pending.
// Three-port lookup tells decode whether any checked register awaits a load.
module load_scoreboard
    import writeback_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  set_valid_i,
    input  logic [REG_ADDR_W-1:0] set_rd_i,
    input  logic                  clr_valid_i,
    input  logic [REG_ADDR_W-1:0] clr_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic [REG_ADDR_W-1:0] rdq_i,
    output logic                  hazard_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // A new issue to a register overrides the retirement of its previous load.
    always_comb begin
        pending_d = pending_q;
        if (clr_valid_i) pending_d[clr_rd_i] = 1'b0;
        if (set_valid_i) pending_d[set_rd_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pending_q <= '0;
        else         pending_q <= pending_d;
    end

    assign hazard_o = pending_q[rs1_i] | pending_q[rs2_i] | pending_q[rdq_i];

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file write-port owner: arbitrates ALU and load results, holds one
// skid-buffered load with a starvation bound, and tracks outstanding loads.
module writeback_ctrl
    import writeback_ctrl_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int STARVE_MAX = 4
) (
    input logic             clk_i,
    input logic             rst_ni,
    writeback_ctrl_if.slave wb
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } req_t;

    logic                buf_valid_q, buf_valid_d;
    req_t                buf_q, buf_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                rf_we_q, rf_we_d;
    req_t                rf_req_q, rf_req_d;
    wb_src_e             src_q, src_d;

    logic    forced_drain, alu_ready, alu_fire, drain, lsu_ready, lsu_fire, capture;
    wb_src_e sel_src;
    req_t    sel_req;

    // Buffer drains whenever the ALU does not take the port; a starved buffer blocks the ALU.
    assign forced_drain = buf_valid_q && (starve_q == STARVE_LIMIT);
    assign alu_ready    = !forced_drain;
    assign alu_fire     = wb.alu_valid_i && alu_ready;
    assign drain        = buf_valid_q && !alu_fire;
    assign lsu_ready    = !buf_valid_q || drain;
    assign lsu_fire     = wb.lsu_valid_i && lsu_ready;
    assign capture      = lsu_fire && (buf_valid_q || alu_fire);

    always_comb begin
        sel_src     = WB_NONE;
        sel_req     = '0;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        starve_d    = starve_q;

        if (drain) begin
            sel_src = WB_LSU;
            sel_req = buf_q;
        end else if (alu_fire) begin
            sel_src = WB_ALU;
            sel_req = '{rd: wb.alu_rd_i, data: wb.alu_data_i};
        end else if (lsu_fire) begin
            sel_src = WB_LSU;
            sel_req = '{rd: wb.lsu_rd_i, data: wb.lsu_data_i};
        end

        if (drain) begin
            buf_valid_d = 1'b0;
            starve_d    = '0;
        end else if (buf_valid_q && (starve_q != STARVE_LIMIT)) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        if (capture) begin
            buf_valid_d = 1'b1;
            buf_d       = '{rd: wb.lsu_rd_i, data: wb.lsu_data_i};
        end

        rf_we_d  = (sel_src != WB_NONE) && (sel_req.rd != '0);
        rf_req_d = (sel_src != WB_NONE) ? sel_req : rf_req_q;
        src_d    = sel_src;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            starve_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_req_q    <= '0;
            src_q       <= WB_NONE;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            starve_q    <= starve_d;
            rf_we_q     <= rf_we_d;
            rf_req_q    <= rf_req_d;
            src_q       <= src_d;
        end
    end

    // Pending bit retires on the same edge the register file captures the load data.
    load_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .set_valid_i (wb.issue_valid_i),
        .set_rd_i    (wb.issue_rd_i),
        .clr_valid_i (rf_we_q && (src_q == WB_LSU)),
        .clr_rd_i    (rf_req_q.rd),
        .rs1_i       (wb.rs1_i),
        .rs2_i       (wb.rs2_i),
        .rdq_i       (wb.rdq_i),
        .hazard_o    (wb.hazard_o)
    );

    assign wb.alu_ready_o  = alu_ready;
    assign wb.lsu_ready_o  = lsu_ready;
    assign wb.rf_we_o      = rf_we_q;
    assign wb.rf_rd_o      = rf_req_q.rd;
    assign wb.rf_rd_data_o = rf_req_q.data;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed plus randomized bench for writeback_ctrl, checked every cycle
// against a queue-based model of the arbitration, buffer and scoreboard rules.
module tb_writeback_ctrl;
    import writeback_ctrl_pkg::*;

    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;

    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    writeback_ctrl_if #(.XLEN(XLEN)) wb_if ();

    writeback_ctrl #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wb     (wb_if.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Model state
    ent_t        m_buf[$];
    int          m_wait;
    bit [31:0]   m_pend;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_we_lsu;
    bit          m_alu_xfer;
    bit          m_lsu_xfer;

    // Current stimulus
    bit          s_av, s_lv, s_iv;
    logic [4:0]  s_ard, s_lrd, s_ird, s_rs1, s_rs2, s_rdq;
    logic [31:0] s_ad, s_ld;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_buf.delete();
        m_wait   = 0;
        m_pend   = '0;
        m_we     = 1'b0;
        m_rd     = '0;
        m_data   = '0;
        m_we_lsu = 1'b0;
    endtask

    function automatic bit expAluReady();
        return !(m_buf.size() == 1 && m_wait == STARVE_MAX);
    endfunction

    function automatic bit expLsuReady();
        if (m_buf.size() == 0) return 1'b1;
        return !(s_av && expAluReady());
    endfunction

    function automatic bit expHazard();
        return (s_rs1 != 0 && m_pend[s_rs1]) || (s_rs2 != 0 && m_pend[s_rs2]) ||
               (s_rdq != 0 && m_pend[s_rdq]);
    endfunction

    task automatic checkAll();
        checkOutput("alu_ready", 32'(wb_if.alu_ready_o), 32'(expAluReady()));
        checkOutput("lsu_ready", 32'(wb_if.lsu_ready_o), 32'(expLsuReady()));
        checkOutput("hazard", 32'(wb_if.hazard_o), 32'(expHazard()));
        checkOutput("rf_we", 32'(wb_if.rf_we_o), 32'(m_we));
        if (m_we) begin
            checkOutput("rf_rd", 32'(wb_if.rf_rd_o), 32'(m_rd));
            checkOutput("rf_data", wb_if.rf_rd_data_o, m_data);
        end
    endtask

    // One clock edge of the reference behaviour, using the stimulus of this cycle.
    task automatic modelStep();
        bit   forced, buf_out, sel_v, sel_lsu, direct;
        ent_t sel;
        forced     = (m_buf.size() == 1) && (m_wait == STARVE_MAX);
        m_alu_xfer = s_av && !forced;
        buf_out    = (m_buf.size() == 1) && !m_alu_xfer;
        m_lsu_xfer = s_lv && (m_buf.size() == 0 || buf_out);
        sel_v = 1'b0; sel_lsu = 1'b0; direct = 1'b0; sel = '0;
        if (buf_out) begin
            sel = m_buf[0]; sel_v = 1'b1; sel_lsu = 1'b1;
        end else if (m_alu_xfer) begin
            sel = '{rd: s_ard, data: s_ad}; sel_v = 1'b1;
        end else if (m_lsu_xfer) begin
            sel = '{rd: s_lrd, data: s_ld}; sel_v = 1'b1; sel_lsu = 1'b1; direct = 1'b1;
        end

        if (m_we && m_we_lsu) m_pend[m_rd] = 1'b0;
        if (s_iv && s_ird != 0) m_pend[s_ird] = 1'b1;

        if (buf_out) begin
            void'(m_buf.pop_front());
            m_wait = 0;
        end else if (m_buf.size() == 1 && m_wait < STARVE_MAX) begin
            m_wait++;
        end
        if (m_lsu_xfer && !direct) m_buf.push_back('{rd: s_lrd, data: s_ld});

        m_we     = sel_v && (sel.rd != 0);
        m_we_lsu = sel_lsu;
        if (sel_v) begin
            m_rd   = sel.rd;
            m_data = sel.data;
        end
    endtask

    task automatic driveInputs();
        wb_if.alu_valid_i   = s_av;  wb_if.alu_rd_i = s_ard; wb_if.alu_data_i = s_ad;
        wb_if.lsu_valid_i   = s_lv;  wb_if.lsu_rd_i = s_lrd; wb_if.lsu_data_i = s_ld;
        wb_if.issue_valid_i = s_iv;  wb_if.issue_rd_i = s_ird;
        wb_if.rs1_i = s_rs1; wb_if.rs2_i = s_rs2; wb_if.rdq_i = s_rdq;
    endtask

    // Drive one cycle of inputs, check against the model, then cross the edge.
    task automatic applyStimulus(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                                 input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                                 input bit iv, input logic [4:0] ird,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdq);
        s_av = av; s_ard = ard; s_ad = ad;
        s_lv = lv; s_lrd = lrd; s_ld = ld;
        s_iv = iv; s_ird = ird;
        s_rs1 = rs1; s_rs2 = rs2; s_rdq = rdq;
        driveInputs();
        #1;
        checkAll();
        modelStep();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idleCycle(input logic [4:0] rs1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, rs1, 0, 0);
    endtask

    bit          a_held, l_held;
    bit          r_av, r_lv, r_iv;
    logic [4:0]  r_ard, r_lrd, r_ird;
    logic [31:0] r_ad, r_ld;

    initial begin
        rst_ni = 1'b0;
        s_av = 0; s_ard = 0; s_ad = 0; s_lv = 0; s_lrd = 0; s_ld = 0;
        s_iv = 0; s_ird = 0; s_rs1 = 0; s_rs2 = 0; s_rdq = 0;
        driveInputs();
        modelReset();
        #12;
        checkOutput("reset_we", 32'(wb_if.rf_we_o), 32'd0);
        checkOutput("reset_rd", 32'(wb_if.rf_rd_o), 32'd0);
        checkOutput("reset_data", wb_if.rf_rd_data_o, 32'd0);
        checkOutput("reset_alu_ready", 32'(wb_if.alu_ready_o), 32'd1);
        checkOutput("reset_lsu_ready", 32'(wb_if.lsu_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #2;

        // ALU only
        applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu_we", 32'(wb_if.rf_we_o), 32'd1);
        checkOutput("alu_rd", 32'(wb_if.rf_rd_o), 32'd5);
        checkOutput("alu_data", wb_if.rf_rd_data_o, 32'h1234);
        idleCycle(0);
        checkOutput("alu_we_pulse", 32'(wb_if.rf_we_o), 32'd0);

        // Collision, ALU idle afterwards
        applyStimulus(1, 6, 32'hA, 1, 7, 32'hB, 0, 0, 0, 0, 0);
        checkOutput("col_alu_rd", 32'(wb_if.rf_rd_o), 32'd6);
        checkOutput("col_alu_data", wb_if.rf_rd_data_o, 32'hA);
        idleCycle(0);
        checkOutput("col_lsu_rd", 32'(wb_if.rf_rd_o), 32'd7);
        checkOutput("col_lsu_data", wb_if.rf_rd_data_o, 32'hB);

        // Collision, ALU valid again: load waits an extra cycle
        applyStimulus(1, 6, 32'hA2, 1, 7, 32'hB2, 0, 0, 0, 0, 0);
        applyStimulus(1, 13, 32'hD, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("col2_alu_rd", 32'(wb_if.rf_rd_o), 32'd13);
        idleCycle(0);
        checkOutput("col2_lsu_rd", 32'(wb_if.rf_rd_o), 32'd7);
        checkOutput("col2_lsu_data", wb_if.rf_rd_data_o, 32'hB2);

        // Starvation
        applyStimulus(1, 1, 32'h11, 1, 8, 32'hC, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 2, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("starve_alu_blocked", 32'(wb_if.alu_ready_o), 32'd0);
        applyStimulus(1, 2, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("starve_lsu_rd", 32'(wb_if.rf_rd_o), 32'd8);
        checkOutput("starve_lsu_data", wb_if.rf_rd_data_o, 32'hC);
        checkOutput("starve_alu_back", 32'(wb_if.alu_ready_o), 32'd1);
        applyStimulus(1, 2, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycle(0);

        // Scoreboard set and clear
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
        checkOutput("sb_hazard_set", 32'(wb_if.hazard_o), 32'd1);
        applyStimulus(0, 0, 0, 1, 9, 32'hFF, 0, 0, 9, 0, 0);
        checkOutput("sb_write_rd", 32'(wb_if.rf_rd_o), 32'd9);
        checkOutput("sb_hazard_at_write", 32'(wb_if.hazard_o), 32'd1);
        idleCycle(9);
        checkOutput("sb_hazard_clear", 32'(wb_if.hazard_o), 32'd0);

        // Set beats clear on the same edge
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 10, 32'h1010, 0, 0, 10, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 10, 0, 0);
        checkOutput("set_wins", 32'(wb_if.hazard_o), 32'd1);

        // x0 write
        applyStimulus(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 10);
        checkOutput("x0_no_we", 32'(wb_if.rf_we_o), 32'd0);

        // Reset with buffer full and x11 pending
        applyStimulus(1, 1, 32'h31, 1, 12, 32'h32, 1, 11, 11, 0, 0);
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_we", 32'(wb_if.rf_we_o), 32'd0);
        checkOutput("rst_hazard", 32'(wb_if.hazard_o), 32'd0);
        modelReset();
        s_av = 0; s_lv = 0; s_iv = 0; s_rs1 = 0;
        driveInputs();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checkOutput("rst_lsu_ready", 32'(wb_if.lsu_ready_o), 32'd1);
        @(posedge clk_i);
        #2;
        checkOutput("rst_no_pulse", 32'(wb_if.rf_we_o), 32'd0);

        // Randomized traffic; producers hold payload until transferred
        a_held = 0; l_held = 0;
        r_av = 0; r_ard = 0; r_ad = 0; r_lv = 0; r_lrd = 0; r_ld = 0;
        for (int i = 0; i < 400; i++) begin
            if (!a_held) begin
                r_av  = ($urandom_range(0, 3) != 0);
                r_ard = 5'($urandom_range(0, 31));
                r_ad  = $urandom;
            end
            if (!l_held) begin
                r_lv  = ($urandom_range(0, 1) != 0);
                r_lrd = 5'($urandom_range(0, 31));
                r_ld  = $urandom;
            end
            r_iv  = ($urandom_range(0, 3) == 0);
            r_ird = 5'($urandom_range(0, 31));
            applyStimulus(r_av, r_ard, r_ad, r_lv, r_lrd, r_ld, r_iv, r_ird,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
            a_held = r_av && !m_alu_xfer;
            l_held = r_lv && !m_lsu_xfer;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
